// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame on
// device clocks, ACK check, bus-idle wait, with an inter-edge timeout.
// Ports:
//   clock, reset (sync, active-high)
//   send, send_data[7:0]              start request and byte to transmit
//   ps2_clock_in, ps2_data_in         raw pin levels (asynchronous)
//   ps2_clock_oe, ps2_data_oe         1 = pull the matching line low
//   busy, done, error                 status; done/error are 1-cycle pulses
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] send_data,
  input  logic       ps2_clock_in,
  input  logic       ps2_data_in,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int CMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                        INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_SHIFT,
    S_ACK,
    S_WAIT
  } state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt, w_cnt_inc;
  logic [3:0]    r_bits, w_bits;
  logic [7:0]    r_shift, w_shift;
  logic          r_par, w_par;
  logic          r_clock_oe, w_clock_oe;
  logic          r_data_oe, w_data_oe;
  logic          r_busy, w_busy;
  logic          r_done, w_done;
  logic          r_error, w_error;

  logic r_clk_s1, r_clk_s2, r_clk_prev;
  logic r_dat_s1, r_dat_s2;
  logic w_fall, w_tmo;

  assign ps2_clock_oe = r_clock_oe;
  assign ps2_data_oe  = r_data_oe;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;

  // Sync stages reset to 1 (idle bus) so leaving reset never fakes an edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clock_in;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= ps2_data_in;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fall    = r_clk_prev & ~r_clk_s2;
  assign w_tmo     = (r_cnt == TMO_LAST);
  assign w_cnt_inc = r_cnt + CW'(1);

  // Next-state logic; the w_*_oe values are the outputs of the NEXT state,
  // so every line change is registered.
  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_bits     = r_bits;
    w_shift    = r_shift;
    w_par      = r_par;
    w_clock_oe = 1'b0;
    w_data_oe  = r_data_oe;
    w_done     = 1'b0;
    w_error    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_data_oe = 1'b0;
        if (send) begin
          w_state    = S_INHIBIT;
          w_shift    = send_data;
          w_par      = ~^send_data;
          w_bits     = '0;
          w_cnt      = '0;
          w_clock_oe = 1'b1;
        end
      end
      S_INHIBIT: begin
        w_clock_oe = 1'b1;
        w_data_oe  = 1'b0;
        if (r_cnt == INH_LAST) begin
          w_state   = S_START;
          w_cnt     = '0;
          w_data_oe = 1'b1;
        end else begin
          w_cnt = w_cnt_inc;
        end
      end
      S_START: begin
        w_state   = S_SHIFT;
        w_cnt     = '0;
        w_data_oe = 1'b1;
      end
      S_SHIFT: begin
        if (w_fall) begin
          w_cnt  = '0;
          w_bits = r_bits + 4'd1;
          if (r_bits < 4'd8) begin
            w_data_oe = ~r_shift[0];
            w_shift   = {1'b0, r_shift[7:1]};
          end else if (r_bits == 4'd8) begin
            w_data_oe = ~r_par;
          end else begin
            w_data_oe = 1'b0;
            w_state   = S_ACK;
          end
        end else if (w_tmo) begin
          w_data_oe = 1'b0;
          w_error   = 1'b1;
          w_state   = S_IDLE;
        end else begin
          w_cnt = w_cnt_inc;
        end
      end
      S_ACK: begin
        w_data_oe = 1'b0;
        if (w_fall) begin
          w_cnt = '0;
          if (!r_dat_s2) begin
            w_state = S_WAIT;
          end else begin
            w_error = 1'b1;
            w_state = S_IDLE;
          end
        end else if (w_tmo) begin
          w_error = 1'b1;
          w_state = S_IDLE;
        end else begin
          w_cnt = w_cnt_inc;
        end
      end
      S_WAIT: begin
        w_data_oe = 1'b0;
        if (r_clk_s2 && r_dat_s2) begin
          w_done  = 1'b1;
          w_state = S_IDLE;
        end else if (w_fall) begin
          w_cnt = '0;
        end else if (w_tmo) begin
          w_error = 1'b1;
          w_state = S_IDLE;
        end else begin
          w_cnt = w_cnt_inc;
        end
      end
      default: begin
        w_data_oe = 1'b0;
        w_state   = S_IDLE;
      end
    endcase

    // busy covers the pulse cycle and drops on the following one.
    w_busy = (w_state != S_IDLE) | w_done | w_error;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bits     <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_clock_oe <= 1'b0;
      r_data_oe  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_bits     <= w_bits;
      r_shift    <= w_shift;
      r_par      <= w_par;
      r_clock_oe <= w_clock_oe;
      r_data_oe  <= w_data_oe;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_error    <= w_error;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model on open-drain pins plus a
// per-cycle timeline model of the host outputs derived from pin events.
module tb_ps2_host_tx;

  localparam int K_NONE = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;
  localparam int K_RST  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       send;
  logic [7:0] send_data;
  logic       dev_clk;
  logic       dev_data;
  logic       ps2_clock_in, ps2_data_in;
  logic       ps2_clock_oe, ps2_data_oe;
  logic       busy, done, error;

  always #5 clk = ~clk;

  // Wired-AND open-drain lines.
  assign ps2_clock_in = dev_clk & ~ps2_clock_oe;
  assign ps2_data_in  = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(20),
    .TIMEOUT_CYCLES(200)
  ) dut (
    .clock       (clk),
    .reset       (reset),
    .send        (send),
    .send_data   (send_data),
    .ps2_clock_in(ps2_clock_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clock_oe(ps2_clock_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit chk_en = 0;

  // Transfer model: acceptance edge, end edge and kind, pin fall cycles.
  bit         has_xfer = 0;
  logic [7:0] m_b;
  int         m_acc, m_end, m_kind;
  int         fall_cyc [12];
  int         nrec;
  int         rel_cyc;

  // Observed events.
  int n_done, n_err;
  int done_cyc, err_cyc, busy_fall;
  int coe_rise, coe_fall, doe_fall;
  logic p_busy = 0, p_coe = 0, p_doe = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  function automatic int nf(input int upto);
    int n = 0;
    for (int i = 0; i < nrec; i++)
      if (fall_cyc[i] <= upto) n++;
    return n;
  endfunction

  // Host data_oe after k device clock falls.
  function automatic logic line_oe(input int k);
    logic par;
    par = ~^m_b;
    if (k == 0) return 1'b1;
    if (k <= 8) return ~m_b[k-1];
    if (k == 9) return ~par;
    return 1'b0;
  endfunction

  logic e_act, e_busy, e_done, e_err, e_coe, e_doe;

  always @(negedge clk) begin
    if (chk_en) begin
      e_act  = has_xfer && cyc >= m_acc && cyc < m_end;
      e_busy = has_xfer && cyc >= m_acc &&
               ((m_kind == K_RST) ? (cyc < m_end) : (cyc <= m_end));
      e_done = has_xfer && m_kind == K_DONE && cyc == m_end;
      e_err  = has_xfer && m_kind == K_ERR && cyc == m_end;
      e_coe  = e_act && cyc <= m_acc + 20;
      e_doe  = e_act && cyc >= m_acc + 20 && line_oe(nf(cyc - 3));
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("error", error, e_err);
      chk("clock_oe", ps2_clock_oe, e_coe);
      chk("data_oe", ps2_data_oe, e_doe);
      if (done) begin n_done++; done_cyc = cyc; end
      if (error) begin n_err++; err_cyc = cyc; end
      if (p_busy && !busy) busy_fall = cyc;
      if (!p_coe && ps2_clock_oe) coe_rise = cyc;
      if (p_coe && !ps2_clock_oe) coe_fall = cyc;
      if (p_doe && !ps2_data_oe && doe_fall < 0) doe_fall = cyc;
    end
    p_busy = busy;
    p_coe  = ps2_clock_oe;
    p_doe  = ps2_data_oe;
  end

  task automatic start_send(input logic [7:0] b);
    nrec = 0;
    m_b = b;
    m_end = 1 << 30;
    m_kind = K_NONE;
    m_acc = cyc + 1;
    has_xfer = 1;
    n_done = 0; n_err = 0;
    done_cyc = -1; err_cyc = -1; busy_fall = -1;
    coe_rise = -1; coe_fall = -1; doe_fall = -1;
    send = 1'b1;
    send_data = b;
    tick(1);
    send = 1'b0;
    send_data = 8'($urandom);
  endtask

  // Device side: sample start, then clock nfalls times (40-cycle period),
  // sampling data at each rising edge; clock 11 is the ACK clock.
  task automatic dev_xfer(input int nfalls, input bit ack, input int hold,
                          output logic [10:0] got);
    got = '0;
    while (cyc < m_acc + 21) tick(1);
    tick($urandom_range(10, 2));
    got[0] = ps2_data_in;
    for (int k = 1; k <= nfalls; k++) begin
      if (k == 11 && !ack) begin
        m_end = cyc + 3;
        m_kind = K_ERR;
      end
      dev_clk = 1'b0;
      fall_cyc[nrec] = cyc;
      nrec++;
      tick(20);
      dev_clk = 1'b1;
      if (k <= 10) got[k] = ps2_data_in;
      if (k == 10 && ack) dev_data = 1'b0;
      if (k == 11 && ack) begin
        tick(hold);
        m_end = cyc + 3;
        m_kind = K_DONE;
        rel_cyc = cyc;
        dev_data = 1'b1;
      end
      tick(20);
    end
  endtask

  logic [10:0] got;
  logic [7:0]  rb;
  bit          rack;

  initial begin
    reset = 1'b1;
    send = 1'b0;
    send_data = '0;
    dev_clk = 1'b1;
    dev_data = 1'b1;
    tick(3);
    chk_en = 1;
    chk("rst_busy", busy, 0);
    chk("rst_coe", ps2_clock_oe, 0);
    chk("rst_doe", ps2_data_oe, 0);
    reset = 1'b0;
    tick(3);

    // 1: 0xED with ACK.
    start_send(8'hED);
    dev_xfer(11, 1'b1, 0, got);
    tick(5);
    chk("t1_frame_lit", got, 11'b11111011010);
    chk("t1_frame", got, frame(8'hED));
    chk("t1_done", n_done, 1);
    chk("t1_err", n_err, 0);
    chk("t1_busy_lag", busy_fall - done_cyc, 1);

    // 2: 0x00 with NACK.
    start_send(8'h00);
    dev_xfer(11, 1'b0, 0, got);
    tick(5);
    chk("t2_frame_lit", got, 11'b11000000000);
    chk("t2_err", n_err, 1);
    chk("t2_done", n_done, 0);
    chk("t2_coe", ps2_clock_oe, 0);
    chk("t2_doe", ps2_data_oe, 0);

    // 3: 0xFF, device never clocks.
    start_send(8'hFF);
    m_end = m_acc + 221;
    m_kind = K_ERR;
    tick(240);
    chk("t3_coe_len", coe_fall - coe_rise, 21);
    chk("t3_tmo", err_cyc - coe_fall, 200);
    chk("t3_err", n_err, 1);
    chk("t3_done", n_done, 0);
    chk("t3_doe", ps2_data_oe, 0);

    // 4: send spam with 0x55 during a 0xF4 transfer.
    start_send(8'hF4);
    fork
      dev_xfer(11, 1'b1, 0, got);
      begin
        for (int i = 0; i < 600 && nrec < 10; i++) begin
          send = 1'b1;
          send_data = 8'h55;
          tick(1);
        end
        send = 1'b0;
      end
    join
    tick(5);
    chk("t4_frame", got, frame(8'hF4));
    chk("t4_done", n_done, 1);
    chk("t4_err", n_err, 0);

    // 5: reset after 5th device clock, then a clean 0xAA.
    start_send(8'hAA);
    dev_xfer(5, 1'b1, 0, got);
    m_end = cyc + 1;
    m_kind = K_RST;
    reset = 1'b1;
    tick(1);
    chk("t5_coe", ps2_clock_oe, 0);
    chk("t5_doe", ps2_data_oe, 0);
    chk("t5_busy", busy, 0);
    tick(1);
    reset = 1'b0;
    tick(3);
    chk("t5_nopulse", n_done + n_err, 0);
    start_send(8'hAA);
    dev_xfer(11, 1'b1, 0, got);
    tick(5);
    chk("t5_frame", got, frame(8'hAA));
    chk("t5_done", n_done, 1);

    // 6: device holds data low 50 cycles after ACK clock.
    start_send(8'hF3);
    dev_xfer(11, 1'b1, 50, got);
    tick(5);
    chk("t6_frame", got, frame(8'hF3));
    chk("t6_done", n_done, 1);
    chk("t6_done_lat", done_cyc - rel_cyc, 3);
    chk("t6_sync_lat", doe_fall - fall_cyc[0], 3);

    // Random bytes, ACK/NACK and hold times.
    for (int r = 0; r < 8; r++) begin
      rb = 8'($urandom);
      rack = ($urandom_range(3, 0) != 0);
      start_send(rb);
      dev_xfer(11, rack, $urandom_range(30, 0), got);
      tick($urandom_range(6, 2));
      chk("rnd_frame", got, frame(rb));
      chk("rnd_done", n_done, rack ? 1 : 0);
      chk("rnd_err", n_err, rack ? 0 : 1);
    end

    tick(5);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard. It is the transmit counterpart of the existing PS/2 receive path. It shares the `ps2_clock`/`ps2_data` open-drain lines, and the top level ties each line low when the matching `_oe` output is 1, otherwise high-Z. It generates the inhibit/request-to-send sequence, shifts out start, data, parity and stop bits on device-generated clocks, checks the device ACK, and reports done or error.

## Interface
Parameters:
- `INHIBIT_CYCLES`, default 6000: `clock` cycles that `ps2_clock` is held low before request-to-send (120 us at 50 MHz).
- `TIMEOUT_CYCLES`, default 1000000: maximum `clock` cycles between consecutive device clock falling edges (20 ms at 50 MHz).

Ports:
- `clock`  in  1: system clock, 50 MHz. The only clock.
- `reset`  in  1: synchronous, active-high.
- `send`  in  1: start request. Sampled only in IDLE.
- `send_data`  in  8: byte to transmit. Captured on the cycle `send` is accepted.
- `ps2_clock_in`  in  1: raw pin level of `ps2_clock`. Asynchronous.
- `ps2_data_in`  in  1: raw pin level of `ps2_data`. Asynchronous.
- `ps2_clock_oe`  out  1: 1 = pull `ps2_clock` low.
- `ps2_data_oe`  out  1: 1 = pull `ps2_data` low.
- `busy`  out  1: high from acceptance until the return to IDLE.
- `done`  out  1: one-cycle pulse when a transfer is ACKed and the bus is back to idle.
- `error`  out  1: one-cycle pulse on NACK or timeout.

## Operation
- Input conditioning: each pin input passes through a 2-FF synchronizer. A falling edge (`fall`) is the previous synced clock = 1 and the current synced clock = 0.
- On acceptance:
  - latch `send_data` into an 8-bit shift register;
  - compute `parity = ~^send_data` (odd parity);
  - clear the bit counter (0..10) and the cycle counter.
- States and transitions:
  - IDLE: both `_oe` = 0. `send` → INHIBIT.
  - INHIBIT: `clock_oe` = 1, `data_oe` = 0. After INHIBIT_CYCLES cycles → START.
  - START: `clock_oe` = 1, `data_oe` = 1 (start bit 0), for exactly 1 cycle → SHIFT.
  - SHIFT: `clock_oe` = 0. `data_oe` stays 1 (start bit).
    - `fall` #1..#8: `data_oe` = ~data[n-1], LSB first.
    - `fall` #9: `data_oe` = ~parity.
    - `fall` #10: `data_oe` = 0 (stop bit 1, line released) → ACK.
  - ACK: on the next `fall`, sample synced data. 0 → WAIT_IDLE. 1 → `error` pulse, IDLE.
  - WAIT_IDLE: when synced clock and synced data are both 1 → `done` pulse, IDLE.
- Timeout:
  - In SHIFT and ACK, the cycle counter clears on every `fall` and increments otherwise.
  - Reaching TIMEOUT_CYCLES → both `_oe` = 0, `error` pulse, IDLE.
  - WAIT_IDLE uses the same counter and rule.
- `send` while `busy` is ignored. `send_data` changes after acceptance have no effect.
- `done` and `error` are never high in the same cycle.
- Reset:
  - values: `ps2_clock_oe` = 0, `ps2_data_oe` = 0, `busy` = 0, `done` = 0, `error` = 0, state IDLE, all counters 0;
  - mid-transfer: both lines are released on that same edge, with no `done` or `error` pulse.

## Timing
- All outputs are registered. Line changes appear 1 cycle after the state decision.
- `send` high at cycle edge T:
  - T+1: `busy` = 1, `clock_oe` = 1.
  - `clock_oe` stays high for INHIBIT_CYCLES + 1 cycles (INHIBIT plus START).
  - `data_oe` rises one cycle before `clock_oe` falls.
- Pin falling edge to `data_oe` update: 3 cycles (2 sync + 1 register). This is well inside the device's half-period (≥30 us).
- `done`/`error` pulse at cycle D, then `busy` = 0 at D+1. A new `send` is accepted at D+1.
- Total line activity: 11 device clocks (10 bits + ACK).

## Test plan
Sim parameters: INHIBIT_CYCLES = 20, TIMEOUT_CYCLES = 200. The device model drives clock with a 40-cycle period.
1. Send 0xED, device ACKs → data line sampled at device clock rising edges reads 0,1,0,1,1,0,1,1,1,1,1 (start, LSB-first 0xED, parity 1, stop 1); `done` one pulse; `error` = 0; `busy` falls 1 cycle later.
2. Send 0x00, device leaves data high at the ACK clock → bits 0, 0×8, parity 1, stop 1; `error` one pulse; `done` never; both `_oe` = 0.
3. Send 0xFF, device never clocks → `clock_oe` high for exactly 21 cycles; `error` pulses 200 cycles after SHIFT entry; both lines released.
4. Pulse `send` with 0x55 every cycle during a 0xF4 transfer → only 0xF4 bits appear; exactly one `done`.
5. Assert `reset` after the 5th device clock of 0xAA → next edge: both `_oe` = 0, `busy` = 0, no `done`/`error`; a following 0xAA transfer completes normally.
6. Hold device data low after the ACK for 50 cycles → `done` delayed until data and clock both read high; verify 3-cycle sync latency.
